// File: rtl/fir_lane_serializer_if.sv
// fir_lane_serializer_if
//   Bundles the word-side and sample-side handshakes of fir_lane_serializer.
//   Signal names are taken from the serializer's point of view.
//   Ports:
//     i_data  : PARALLELISM packed signed lanes of NB_OUT bits, lane 0 oldest
//     i_valid : input word valid
//     o_ready : serializer can accept an input word
//     o_data  : serial signed sample, NB_SER bits
//     o_valid : o_data valid
//     i_ready : downstream accepts o_data
//     o_last  : current sample is the last lane of its word
//     o_ovf   : current sample did not fit in NB_SER bits
//   Modports: slave = the serializer, master = the surrounding environment.
interface fir_lane_serializer_if #(
  parameter int PARALLELISM = 2,
  parameter int NB_OUT      = 19,
  parameter int NB_SER      = 19
);
  logic        [NB_OUT*PARALLELISM-1:0] i_data;
  logic                                 i_valid;
  logic                                 o_ready;
  logic signed [NB_SER-1:0]             o_data;
  logic                                 o_valid;
  logic                                 i_ready;
  logic                                 o_last;
  logic                                 o_ovf;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_last, o_ovf
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_last, o_ovf
  );
endinterface

// File: rtl/fir_lane_serializer.sv
// fir_lane_serializer
//   Accepts one word of PARALLELISM FIR output lanes per handshake and emits
//   the lanes one sample per accepted beat, lane 0 first. A 2-word buffer
//   absorbs back-pressure. Samples can be narrowed from NB_OUT to NB_SER bits;
//   out-of-range samples raise o_ovf.
//   Build option: define FIR_LANE_SER_SAT_EN to saturate out-of-range
//   samples; otherwise they wrap (NB_SER LSBs kept).
//   Ports:
//     i_clock : clock
//     i_rst_n : asynchronous active-low reset
//     bus     : fir_lane_serializer_if.slave (word input, serial output)
module fir_lane_serializer #(
  parameter int PARALLELISM = 2,
  parameter int NB_OUT      = 19,
  parameter int NB_SER      = 19
) (
  input  logic                      i_clock,
  input  logic                      i_rst_n,
  fir_lane_serializer_if.slave      bus
);

  localparam int IDX_W  = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1;
  localparam int WORD_W = NB_OUT * PARALLELISM;

  // Sample does not fit when the bits above the NB_SER sign bit are not a
  // pure sign extension.
  function automatic logic ovf_chk(input logic signed [NB_OUT-1:0] v);
    logic [NB_OUT-NB_SER:0] top;
    top = v[NB_OUT-1:NB_SER-1];
    return !((&top) || !(|top));
  endfunction

  function automatic logic signed [NB_SER-1:0] reduce(input logic signed [NB_OUT-1:0] v);
`ifdef FIR_LANE_SER_SAT_EN
    if (ovf_chk(v))
      return v[NB_OUT-1] ? {1'b1, {(NB_SER-1){1'b0}}} : {1'b0, {(NB_SER-1){1'b1}}};
    else
      return v[NB_SER-1:0];
`else
    return v[NB_SER-1:0];
`endif
  endfunction

  // Word buffer (data only, no reset needed)
  logic [WORD_W-1:0]       mem_p0 [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              count;
  logic [1:0]              count_n;
  logic [IDX_W-1:0]        idx;
  logic                    ready_q;

  logic                    push;
  logic                    pop;
  logic                    retire;
  logic                    vld_p0;
  logic                    lane_last;
  logic [WORD_W-1:0]       head_p0;
  logic signed [NB_OUT-1:0] lane_p0;

  assign vld_p0    = (count != 2'd0);
  assign lane_last = (idx == IDX_W'(PARALLELISM-1));
  assign push      = bus.i_valid && ready_q;
  assign pop       = vld_p0 && bus.i_ready;
  assign retire    = pop && lane_last;
  assign count_n   = count + {1'b0, push} - {1'b0, retire};
  assign head_p0   = mem_p0[rd_ptr];

  always_comb begin
    lane_p0 = '0;
    for (int k = 0; k < PARALLELISM; k++)
      if (idx == IDX_W'(k)) lane_p0 = head_p0[k*NB_OUT +: NB_OUT];
  end

  // Control state
  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      idx     <= '0;
      ready_q <= 1'b0;
    end else begin
      count   <= count_n;
      // o_ready is registered from the next occupancy so that it never
      // depends combinationally on i_ready.
      ready_q <= (count_n != 2'd2);
      if (push) wr_ptr <= ~wr_ptr;
      if (retire) begin
        rd_ptr <= ~rd_ptr;
        idx    <= '0;
      end else if (pop) begin
        idx    <= idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) mem_p0[wr_ptr] <= bus.i_data;
  end

  // Output stage: gated by valid so outputs read zero while empty
  assign bus.o_ready = ready_q;
  assign bus.o_valid = vld_p0;
  assign bus.o_data  = vld_p0 ? reduce(lane_p0) : '0;
  assign bus.o_last  = vld_p0 && lane_last;
  assign bus.o_ovf   = vld_p0 && ovf_chk(lane_p0);

endmodule

// File: tb/tb_fir_lane_serializer.sv
module tb_fir_lane_serializer;

  logic i_clock = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clock = ~i_clock;

  fir_lane_serializer_if #(.PARALLELISM(2), .NB_OUT(19), .NB_SER(19)) bus0 ();
  fir_lane_serializer_if #(.PARALLELISM(2), .NB_OUT(19), .NB_SER(12)) bus1 ();
  fir_lane_serializer_if #(.PARALLELISM(1), .NB_OUT(19), .NB_SER(19)) bus2 ();

  fir_lane_serializer #(.PARALLELISM(2), .NB_OUT(19), .NB_SER(19)) u_main (
    .i_clock(i_clock), .i_rst_n(i_rst_n), .bus(bus0));
  fir_lane_serializer #(.PARALLELISM(2), .NB_OUT(19), .NB_SER(12)) u_narrow (
    .i_clock(i_clock), .i_rst_n(i_rst_n), .bus(bus1));
  fir_lane_serializer #(.PARALLELISM(1), .NB_OUT(19), .NB_SER(19)) u_single (
    .i_clock(i_clock), .i_rst_n(i_rst_n), .bus(bus2));

  int n_chk = 0;
  int n_err = 0;

`ifdef FIR_LANE_SER_SAT_EN
  localparam longint EXP_POS3000 = 2047;
  localparam longint EXP_NEG3000 = -2048;
`else
  localparam longint EXP_POS3000 = -1096;
  localparam longint EXP_NEG3000 = 1096;
`endif

  task automatic chk(input string tag, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  function automatic logic [37:0] pack2(input int a0, input int a1);
    return {19'(a1), 19'(a0)};
  endfunction

  logic signed [18:0] got [$];
  logic signed [18:0] exp_bp [6];
  bit fin, acc;

  initial begin
    bus0.i_data = '0; bus0.i_valid = 1'b0; bus0.i_ready = 1'b1;
    bus1.i_data = '0; bus1.i_valid = 1'b0; bus1.i_ready = 1'b1;
    bus2.i_data = '0; bus2.i_valid = 1'b0; bus2.i_ready = 1'b1;

    // Reset state
    @(negedge i_clock);
    chk("rst_ready", bus0.o_ready, 0);
    chk("rst_valid", bus0.o_valid, 0);
    chk("rst_data",  bus0.o_data,  0);
    chk("rst_last",  bus0.o_last,  0);
    chk("rst_ovf",   bus0.o_ovf,   0);
    @(negedge i_clock);
    i_rst_n = 1'b1;
    tick;
    chk("post_rst_ready", bus0.o_ready, 1);
    chk("post_rst_valid", bus0.o_valid, 0);

    // Basic order: {5,-3} then {7,9}
    bus0.i_data = pack2(5, -3); bus0.i_valid = 1'b1;
    tick;
    chk("basic_d0", bus0.o_data, 5);
    chk("basic_l0", bus0.o_last, 0);
    chk("basic_v0", bus0.o_valid, 1);
    bus0.i_data = pack2(7, 9);
    tick;
    bus0.i_valid = 1'b0;
    chk("basic_d1", bus0.o_data, -3);
    chk("basic_l1", bus0.o_last, 1);
    chk("basic_o1", bus0.o_ovf, 0);
    tick;
    chk("basic_d2", bus0.o_data, 7);
    chk("basic_l2", bus0.o_last, 0);
    tick;
    chk("basic_d3", bus0.o_data, 9);
    chk("basic_l3", bus0.o_last, 1);
    tick;
    chk("basic_empty", bus0.o_valid, 0);

    // Back-pressure: three words offered while downstream stalls
    bus0.i_ready = 1'b0;
    bus0.i_data = pack2(11, 12); bus0.i_valid = 1'b1;
    tick;
    chk("bp_ready1", bus0.o_ready, 1);
    chk("bp_data1", bus0.o_data, 11);
    bus0.i_data = pack2(13, 14);
    tick;
    chk("bp_ready2", bus0.o_ready, 0);
    bus0.i_data = pack2(15, 16);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("bp_hold_ready", bus0.o_ready, 0);
      chk("bp_hold_data", bus0.o_data, 11);
      chk("bp_hold_last", bus0.o_last, 0);
      chk("bp_hold_valid", bus0.o_valid, 1);
    end
    bus0.i_ready = 1'b1;
    got.delete();
    acc = 1'b0;
    for (int c = 0; c < 20 && got.size() < 6; c++) begin
      if (acc) bus0.i_valid = 1'b0;
      fin = bus0.i_valid && bus0.o_ready;
      if (bus0.o_valid && bus0.i_ready) got.push_back(bus0.o_data);
      tick;
      if (fin) acc = 1'b1;
    end
    bus0.i_valid = 1'b0;
    exp_bp = '{19'sd11, 19'sd12, 19'sd13, 19'sd14, 19'sd15, 19'sd16};
    chk("bp_count", got.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) chk($sformatf("bp_order%0d", i), got[i], exp_bp[i]);
    chk("bp_drained", bus0.o_valid, 0);

    // Simultaneous push and retire with one word buffered
    bus0.i_data = pack2(21, 22); bus0.i_valid = 1'b1;
    tick;
    bus0.i_valid = 1'b0;
    chk("sim_d0", bus0.o_data, 21);
    tick;
    chk("sim_d1", bus0.o_data, 22);
    bus0.i_data = pack2(23, 24); bus0.i_valid = 1'b1;
    chk("sim_ready", bus0.o_ready, 1);
    tick;
    bus0.i_valid = 1'b0;
    chk("sim_new_d0", bus0.o_data, 23);
    chk("sim_new_last", bus0.o_last, 0);
    tick;
    chk("sim_new_d1", bus0.o_data, 24);
    tick;
    chk("sim_count1", bus0.o_valid, 0);

    // Reset mid-word: lane 0 consumed, lane 1 pending
    bus0.i_data = pack2(31, 32); bus0.i_valid = 1'b1;
    tick;
    bus0.i_valid = 1'b0;
    chk("rmw_d0", bus0.o_data, 31);
    tick;
    chk("rmw_d1", bus0.o_data, 32);
    bus0.i_ready = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("rmw_valid_async", bus0.o_valid, 0);
    chk("rmw_ready_async", bus0.o_ready, 0);
    @(negedge i_clock);
    i_rst_n = 1'b1;
    bus0.i_ready = 1'b1;
    tick;
    chk("rmw_ready_rel", bus0.o_ready, 1);
    chk("rmw_no_stale", bus0.o_valid, 0);
    tick;
    chk("rmw_no_stale2", bus0.o_valid, 0);

    // Width reduction to 12 bits
    bus1.i_data = pack2(3000, -2048); bus1.i_valid = 1'b1;
    tick;
    bus1.i_data = pack2(-3000, 2047);
    chk("nar_3000", bus1.o_data, EXP_POS3000);
    chk("nar_3000_ovf", bus1.o_ovf, 1);
    tick;
    bus1.i_valid = 1'b0;
    chk("nar_m2048", bus1.o_data, -2048);
    chk("nar_m2048_ovf", bus1.o_ovf, 0);
    tick;
    chk("nar_m3000", bus1.o_data, EXP_NEG3000);
    chk("nar_m3000_ovf", bus1.o_ovf, 1);
    tick;
    chk("nar_2047", bus1.o_data, 2047);
    chk("nar_2047_ovf", bus1.o_ovf, 0);
    tick;
    chk("nar_empty", bus1.o_valid, 0);

    // PARALLELISM=1 pass-through stream 1..16
    for (int k = 1; k <= 17; k++) begin
      if (k > 1) begin
        chk($sformatf("p1_valid%0d", k-1), bus2.o_valid, 1);
        chk($sformatf("p1_data%0d", k-1), bus2.o_data, k-1);
        chk($sformatf("p1_last%0d", k-1), bus2.o_last, 1);
      end
      if (k <= 16) begin
        chk($sformatf("p1_ready%0d", k), bus2.o_ready, 1);
        bus2.i_data = 19'(k);
        bus2.i_valid = 1'b1;
      end else begin
        bus2.i_valid = 1'b0;
      end
      tick;
    end
    chk("p1_empty", bus2.o_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
